div_radix2: RTL
===============

Name: div_radix2

Overview:
- Multi-cycle 32-bit signed/unsigned radix-2 restoring divider.
- Consumes the operand/start/signedness request that the execute stage drives for DIV/DIVU.
- Returns a 64-bit {remainder, quotient} result plus a ready flag to the execute stage.
- The execute stage holds the pipeline stalled until ready is seen.

Parameters:
- None. Widths come from the shared defines: 32-bit RegBus, 64-bit DoubleRegBus.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; held high by the execute stage until it sees ready_o.
- annul_i  in  1  cancel in-flight division (flush).
- result_o  out  64  [63:32] remainder, [31:0] quotient; registered.
- ready_o  out  1  result valid; registered.

Behaviour:
- Reset: state=FREE, cnt=0, working register=0, result_o=0, ready_o=0. Applies in any state, including mid-operation.
- Operands are sampled only on the FREE->ON/BYZERO transition. Later changes on opdata*_i or signed_div_i are ignored.
- Internal 65-bit working register {partial remainder, dividend}. Absolute values are used when signed_div_i=1; raw values otherwise.
- States:
  - FREE: if start_i && !annul_i: divisor==0 -> BYZERO, else -> ON (cnt=0, working reg={32'b0, |dividend|, 1'b0}). Otherwise stay; ready_o=0, result_o=0.
  - BYZERO: next edge -> END with working reg=0 (quotient 0, remainder 0).
  - ON, annul_i=1: -> FREE, outputs cleared.
  - ON, cnt<32: one iteration per cycle. Trial subtract |divisor| from working[63:32]. Negative -> shift left, LSB 0. Else -> {diff, working[31:0], 1'b1}. cnt++.
  - ON, cnt==32: sign correction, then -> END. Quotient = working[31:0], negated if signed && op1[31]^op2[31]. Remainder = working[64:33], negated if signed && op1[31].
  - END: result_o <= {remainder, quotient}, ready_o <= 1. If start_i==0 -> FREE with ready_o<=0, result_o<=0. Else stay in END, outputs held.
- Latency: start first sampled at edge E0 -> ready_o visible after E0+34. Divide-by-zero: after E0+2.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (wraps, no trap).
- annul_i in BYZERO or END: ignored. END still exits only on start_i==0.
- start_i asserted while in ON: no effect, no restart.

Optional Feature:
- Macro: DIV_EARLY_TERM_EN.
- Defined: on FREE->ON, lz = leading-zero count of |dividend| (32 if zero). Working reg is preloaded with |dividend| << lz, and cnt is initialised to lz.
  - Ready after E0+34-lz.
  - Dividend 0 -> ready after E0+2.
  - Results bit-identical to the non-feature build.
- Undefined: fixed 32 iterations; no CLZ logic instantiated.

Decomposition:
- Shared defines file holds:
  - state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - DivResultReady/NotReady and DivStart/DivStop;
  - ZeroWord, RegBus, DoubleRegBus.
- Sub-module div_clz32 (32-bit leading-zero counter, 6-bit output), instantiated only under DIV_EARLY_TERM_EN.

Test Plan:
- Unsigned: op1=100, op2=7, signed=0, start held -> ready_o=1 at E0+34; result_o=0x00000002_0000000E. Drop start -> next cycle ready_o=0, result_o=0.
- Signed signs: -7/2 -> {0xFFFFFFFF, 0xFFFFFFFD}. 7/-2 -> {0x00000001, 0xFFFFFFFD}. -7/-2 -> {0xFFFFFFFF, 0x00000003}.
- Divide-by-zero: op1=0x12345678, op2=0 -> ready_o=1 at E0+2, result_o=0.
- Overflow and unsigned max:
  - signed 0x80000000/0xFFFFFFFF -> {0, 0x80000000};
  - unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- Annul and reset: annul_i=1 at cnt=10 -> FREE, ready never asserts; a new start then completes normally. rst=1 mid-ON -> all outputs 0 next cycle.
- DIV_EARLY_TERM_EN build: op1=5, op2=2 (lz=29) -> ready at E0+5, result {1, 2}. Random signed/unsigned sweep matches the non-feature build bit-for-bit.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// Shared widths, state encodings and handshake constants for the radix-2 divider.
// Build option: DIV_EARLY_TERM_EN (see div_radix2.sv).
package div_radix2_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Magnitude of an operand; unsigned requests pass straight through.
  function automatic logic [RegBus-1:0] abs_val(input logic is_signed,
                                                input logic [RegBus-1:0] value);
    return (is_signed && value[RegBus-1]) ? (ZeroWord - value) : value;
  endfunction

endpackage

// File: rtl/div_radix2_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_radix2_if;
  import div_radix2_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_radix2_clz32.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module div_clz32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Scanning upward, the highest set bit writes last and wins.
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (value[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle 32-bit signed/unsigned radix-2 restoring divider, result = {remainder, quotient}.
// Define DIV_EARLY_TERM_EN to skip the dividend's leading-zero iterations.
module div_radix2
  import div_radix2_pkg::*;
(
  input logic         clk,
  input logic         rst,
  div_radix2_if.slave bus
);

  div_state_e        state;
  logic [5:0]        cnt;
  logic [64:0]       work;
  logic [RegBus-1:0] divisor_abs;
  logic              neg_quot;
  logic              neg_rem;

  logic [RegBus-1:0] op1_abs;
  logic [RegBus-1:0] op2_abs;
  logic [64:0]       init_work;
  logic [5:0]        init_cnt;
  logic [RegBus:0]   trial;
  logic [RegBus-1:0] quot_fix;
  logic [RegBus-1:0] rem_fix;

  assign op1_abs = abs_val(bus.signed_div_i, bus.opdata1_i);
  assign op2_abs = abs_val(bus.signed_div_i, bus.opdata2_i);

`ifdef DIV_EARLY_TERM_EN
  logic [5:0] lz;

  div_clz32 u_clz (
    .value (op1_abs),
    .count (lz)
  );

  // Leading zeros would only shift zeros through the remainder, so start past them.
  assign init_work = {ZeroWord, op1_abs << lz, 1'b0};
  assign init_cnt  = lz;
`else
  assign init_work = {ZeroWord, op1_abs, 1'b0};
  assign init_cnt  = 6'd0;
`endif

  assign trial    = {1'b0, work[63:32]} - {1'b0, divisor_abs};
  assign quot_fix = neg_quot ? (ZeroWord - work[31:0])  : work[31:0];
  assign rem_fix  = neg_rem  ? (ZeroWord - work[64:33]) : work[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= 6'd0;
      work         <= '0;
      divisor_abs  <= ZeroWord;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          bus.ready_o  <= DivResultNotReady;
          bus.result_o <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            divisor_abs <= op2_abs;
            neg_quot    <= bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
            neg_rem     <= bus.signed_div_i & bus.opdata1_i[31];
            if (bus.opdata2_i == ZeroWord) begin
              state <= DivByZero;
            end else begin
              state <= DivOn;
              cnt   <= init_cnt;
              work  <= init_work;
            end
          end
        end

        DivByZero: begin
          work  <= '0;
          state <= DivEnd;
        end

        DivOn: begin
          if (bus.annul_i) begin
            state        <= DivFree;
            cnt          <= 6'd0;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
          end else if (cnt != 6'd32) begin
            if (trial[RegBus]) work <= {work[63:0], 1'b0};
            else               work <= {trial[RegBus-1:0], work[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            // Corrected result parked in the low 64 bits for the END state to publish.
            work  <= {1'b0, rem_fix, quot_fix};
            cnt   <= 6'd0;
            state <= DivEnd;
          end
        end

        DivEnd: begin
          bus.result_o <= work[63:0];
          bus.ready_o  <= DivResultReady;
          if (bus.start_i == DivStop) begin
            state        <= DivFree;
            bus.result_o <= '0;
            bus.ready_o  <= DivResultNotReady;
          end
        end

        default: state <= DivFree;
      endcase
    end
  end

endmodule
